// File: rtl/pipe_hazard_ctrl.sv
// Hazard scheduler for the 5-stage RV32I pipeline: load-use bubbles, EX redirects,
// D-memory wait states with a timeout watchdog, plus stall/flush/wait event counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [4:0]       rs1_IFID,
  input  logic [4:0]       rs2_IFID,
  input  logic             useRs1_IFID,
  input  logic             useRs2_IFID,
  input  logic [4:0]       rd_IDEX,
  input  logic             isLoad_IDEX,
  input  logic             redirect_EX,
  input  logic             memReq_MEM,
  input  logic             memAck,
  output logic             PC_WE,
  output logic             IFID_WE,
  output logic             IDEX_WE,
  output logic             EXMEM_WE,
  output logic             MEMWB_WE,
  output logic             PC_SEL,
  output logic             IFID_FLUSH,
  output logic             IDEX_FLUSH,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0]    TIMER_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0]    state;
  logic [1:0]    eff_state;
  logic [TW-1:0] timer;
  logic          load_use;
  logic          mem_busy;
  logic          do_stall;
  logic          do_flush;
  logic          do_wait;

  assign load_use = isLoad_IDEX && (rd_IDEX != 5'd0) &&
                    ((useRs1_IFID && (rs1_IFID == rd_IDEX)) ||
                     (useRs2_IFID && (rs2_IFID == rd_IDEX)));
  assign mem_busy = memReq_MEM && !memAck;

  // While reset is held the controls already behave as if the FSM were in RUN.
  assign eff_state = RSTn ? state : RUN;
  assign mem_err   = (state == ERR);

  always_comb begin
    PC_WE      = 1'b1;
    IFID_WE    = 1'b1;
    IDEX_WE    = 1'b1;
    EXMEM_WE   = 1'b1;
    MEMWB_WE   = 1'b1;
    PC_SEL     = 1'b0;
    IFID_FLUSH = 1'b0;
    IDEX_FLUSH = 1'b0;
    do_stall   = 1'b0;
    do_flush   = 1'b0;
    do_wait    = 1'b0;
    if (eff_state == ERR || mem_busy) begin
      PC_WE    = 1'b0;
      IFID_WE  = 1'b0;
      IDEX_WE  = 1'b0;
      EXMEM_WE = 1'b0;
      MEMWB_WE = 1'b0;
      do_wait  = (eff_state != ERR);
    end else if (redirect_EX) begin
      // The dependent instruction is squashed, so a redirect overrides load-use.
      PC_SEL     = 1'b1;
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
      do_flush   = 1'b1;
    end else if (load_use) begin
      PC_WE      = 1'b0;
      IFID_WE    = 1'b0;
      IDEX_FLUSH = 1'b1;
      do_stall   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= RUN;
      timer     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          timer <= '0;
          if (mem_busy) state <= WAIT;
        end
        WAIT: begin
          if (!mem_busy) begin
            state <= RUN;
            timer <= '0;
          end else if (timer == TIMER_LAST) begin
            state <= ERR;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        default: state <= ERR;
      endcase
      if (do_stall) stall_cnt <= stall_cnt + CNT_ONE;
      if (do_flush) flush_cnt <= flush_cnt + CNT_ONE;
      if (do_wait)  wait_cnt  <= wait_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with 4-bit counters and a 4-cycle memory timeout.
module tb_pipe_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic [4:0] rs1_IFID, rs2_IFID, rd_IDEX;
  logic       useRs1_IFID, useRs2_IFID, isLoad_IDEX;
  logic       redirect_EX, memReq_MEM, memAck;
  logic       PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE;
  logic       PC_SEL, IFID_FLUSH, IDEX_FLUSH, mem_err;
  logic [3:0] stall_cnt, flush_cnt, wait_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] CTRL_RUN    = 8'hF8;
  localparam logic [7:0] CTRL_STALL  = 8'h39;
  localparam logic [7:0] CTRL_REDIR  = 8'hFF;
  localparam logic [7:0] CTRL_FROZEN = 8'h00;

  pipe_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID),
    .useRs1_IFID(useRs1_IFID), .useRs2_IFID(useRs2_IFID),
    .rd_IDEX(rd_IDEX), .isLoad_IDEX(isLoad_IDEX),
    .redirect_EX(redirect_EX), .memReq_MEM(memReq_MEM), .memAck(memAck),
    .PC_WE(PC_WE), .IFID_WE(IFID_WE), .IDEX_WE(IDEX_WE),
    .EXMEM_WE(EXMEM_WE), .MEMWB_WE(MEMWB_WE), .PC_SEL(PC_SEL),
    .IFID_FLUSH(IFID_FLUSH), .IDEX_FLUSH(IDEX_FLUSH), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] ctrl();
    return {PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE, PC_SEL, IFID_FLUSH, IDEX_FLUSH};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic ld, input logic redir,
                       input logic req, input logic ack);
    rs1_IFID = rs1; rs2_IFID = rs2; useRs1_IFID = u1; useRs2_IFID = u2;
    rd_IDEX = rd; isLoad_IDEX = ld; redirect_EX = redir;
    memReq_MEM = req; memAck = ack;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic counters(input string tag, input logic [3:0] s, input logic [3:0] f, input logic [3:0] w);
    check({tag, "_stall"}, 32'(stall_cnt), 32'(s));
    check({tag, "_flush"}, 32'(flush_cnt), 32'(f));
    check({tag, "_wait"},  32'(wait_cnt),  32'(w));
  endtask

  initial begin
    RSTn = 1'b0;
    idle();
    tick();
    tick();
    RSTn = 1'b1;
    #3;
    check("reset_ctrl", 32'(ctrl()), 32'(CTRL_RUN));
    check("reset_memerr", 32'(mem_err), 32'd0);
    counters("reset", 4'd0, 4'd0, 4'd0);

    // LW x5 in ID/EX, ADD reading x5 through rs2 in IF/ID.
    drive(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    check("loaduse_ctrl", 32'(ctrl()), 32'(CTRL_STALL));
    tick();
    idle();
    #3;
    check("loaduse_next_ctrl", 32'(ctrl()), 32'(CTRL_RUN));
    counters("loaduse", 4'd1, 4'd0, 4'd0);

    drive(5'd0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    check("rd_x0_ctrl", 32'(ctrl()), 32'(CTRL_RUN));
    tick();
    drive(5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    check("unused_rs1_ctrl", 32'(ctrl()), 32'(CTRL_RUN));
    tick();
    idle();
    #3;
    counters("noload", 4'd1, 4'd0, 4'd0);

    drive(5'd5, 5'd9, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    #3;
    check("redir_loaduse_ctrl", 32'(ctrl()), 32'(CTRL_REDIR));
    tick();
    idle();
    #3;
    counters("redir", 4'd1, 4'd1, 4'd0);

    // Three frozen cycles with a redirect pending, then the ack releases it.
    drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #3;
      check($sformatf("memwait_ctrl%0d", i), 32'(ctrl()), 32'(CTRL_FROZEN));
      tick();
    end
    memAck = 1'b1;
    #3;
    check("memack_ctrl", 32'(ctrl()), 32'(CTRL_REDIR));
    counters("memwait", 4'd1, 4'd1, 4'd3);
    tick();
    idle();
    #3;
    check("after_ack_ctrl", 32'(ctrl()), 32'(CTRL_RUN));
    counters("after_ack", 4'd1, 4'd2, 4'd3);

    drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    #3;
    check("req_ack_same_ctrl", 32'(ctrl()), 32'(CTRL_RUN));
    tick();
    idle();
    #3;
    counters("req_ack_same", 4'd1, 4'd2, 4'd3);

    // Timeout: entry cycle plus four WAIT cycles with memBusy.
    drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    #3;
    check("pre_timeout_memerr", 32'(mem_err), 32'd0);
    check("pre_timeout_ctrl", 32'(ctrl()), 32'(CTRL_FROZEN));
    tick();
    #3;
    check("timeout_memerr", 32'(mem_err), 32'd1);
    drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    #3;
    check("err_ctrl", 32'(ctrl()), 32'(CTRL_FROZEN));
    check("err_memerr", 32'(mem_err), 32'd1);
    counters("err", 4'd1, 4'd2, 4'd8);

    RSTn = 1'b0;
    idle();
    #3;
    check("reset_low_ctrl", 32'(ctrl()), 32'(CTRL_RUN));
    tick();
    RSTn = 1'b1;
    #3;
    check("post_reset_memerr", 32'(mem_err), 32'd0);
    counters("post_reset", 4'd0, 4'd0, 4'd0);

    // Seventeen stalls wrap the 4-bit counter to 1.
    drive(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) tick();
    idle();
    #3;
    check("wrap_stall", 32'(stall_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline scheduler for the 5-stage RV32I core. It sits beside the instruction decoder and drives the write-enable, flush and PC-select controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It handles three cases: load-use bubbles, EX-resolved branch/jump redirects, and D-memory wait states with a timeout watchdog. It also keeps stall/flush/wait event counters for performance debug.

## Interface
- CNT_W, 32, width of each event counter
- MEM_TIMEOUT, 64, WAIT cycles before mem_err is raised (≥1)
- CLK  in  1  clock, rising edge
- RSTn  in  1  reset, synchronous, active-low
- rs1_IFID, rs2_IFID  in  5 each  source registers of the instruction in IF/ID
- useRs1_IFID, useRs2_IFID  in  1 each  the instruction actually reads rs1 / rs2
- rd_IDEX  in  5  destination register of the instruction in ID/EX
- isLoad_IDEX  in  1  the instruction in ID/EX is a load
- redirect_EX  in  1  taken branch or jump resolved in EX this cycle
- memReq_MEM  in  1  load/store occupying MEM
- memAck  in  1  D-memory completes the MEM access this cycle
- PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE  out  1 each  stage register enables
- PC_SEL  out  1  1 = load redirect target, 0 = PC+4
- IFID_FLUSH, IDEX_FLUSH  out  1 each  load a NOP/bubble into the register (only effective with that register's WE=1)
- mem_err  out  1  sticky D-memory timeout flag
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  event counters

## Operation
- FSM states: RUN, WAIT, ERR.
- Outputs are combinational from state plus current inputs. State, wait timer and counters are registered.
- Derived signals:
  - loadUse = isLoad_IDEX & rd_IDEX≠0 & ((useRs1_IFID & rs1_IFID==rd_IDEX) | (useRs2_IFID & rs2_IFID==rd_IDEX))
  - memBusy = memReq_MEM & ~memAck
- Priority, highest first:
  1. state ERR: all WE=0, all FLUSH=0, PC_SEL=0. No exit except reset.
  2. memBusy (in RUN or WAIT): freeze. All WE=0, FLUSH=0, PC_SEL=0. Redirect and loadUse are ignored this cycle; they are re-evaluated once unfrozen, because the frozen registers hold their inputs stable.
  3. redirect_EX: PC_SEL=1; PC_WE=IFID_WE=IDEX_WE=EXMEM_WE=MEMWB_WE=1; IFID_FLUSH=IDEX_FLUSH=1. Redirect suppresses loadUse, since the dependent instruction is squashed.
  4. loadUse: PC_WE=0, IFID_WE=0, IDEX_WE=1 with IDEX_FLUSH=1, EXMEM_WE=MEMWB_WE=1, PC_SEL=0.
  5. otherwise: all WE=1, FLUSH=0, PC_SEL=0.
- Transitions:
  - RUN→WAIT when memBusy.
  - WAIT stays while memBusy. WAIT→RUN on the cycle memAck=1 (or memReq_MEM=0); that cycle applies rules 3–5.
  - WAIT→ERR when the wait timer equals MEM_TIMEOUT-1 and memBusy still holds.
- Wait timer:
  - Cleared on entry to WAIT and in RUN.
  - Increments each WAIT cycle with memBusy.
- Counters, each wrapping modulo 2^CNT_W:
  - stall_cnt +1 per cycle rule 4 applies.
  - flush_cnt +1 per cycle rule 3 applies.
  - wait_cnt +1 per cycle rule 2 applies.
- mem_err = (state==ERR).

## Timing
- Reset: RSTn sampled low at a CLK edge sets state=RUN, timer=0, all counters=0, mem_err=0.
  - While RSTn is low, outputs follow the RUN rules on current inputs.
  - Reset mid-WAIT or in ERR returns to RUN on that edge.
- Zero latency: hazard outputs respond in the same cycle as the inputs.
- A load-use stall lasts exactly 1 cycle per dependent load. On the next cycle the load has moved to MEM and loadUse clears naturally.
- A memAck arriving in the same cycle memReq_MEM rises causes no freeze and no WAIT entry.
- With MEM_TIMEOUT=N, mem_err rises on the edge after N consecutive memBusy cycles counted from WAIT entry. That is N+1 frozen cycles including the entry cycle.
- Counters update on the edge ending the qualifying cycle and are visible the next cycle.

## Test plan
- Load-use: LW x5 in ID/EX, ADD using rs2=x5 in IF/ID, no memReq. Required: 1 cycle with PC_WE=0, IFID_WE=0, IDEX_FLUSH=1; stall_cnt 0→1; next cycle all WE=1.
- rd=x0 / unused operand: LW x0, or rs1 match with useRs1_IFID=0. Required: no stall, stall_cnt unchanged.
- Redirect plus loadUse in the same cycle. Required: PC_SEL=1, IFID_FLUSH=IDEX_FLUSH=1, PC_WE=1; flush_cnt+1, stall_cnt unchanged.
- Memory wait: memReq_MEM=1, memAck low for 3 cycles then high, with redirect_EX held high. Required: 3 cycles with all WE=0; wait_cnt=3; on the ack cycle redirect applies (flush_cnt+1); state returns to RUN.
- Timeout, MEM_TIMEOUT=4, memAck never asserted. Required: mem_err=1 after 4 WAIT cycles; WE outputs stay 0 indefinitely; RSTn low for one edge clears mem_err and the counters.
- Counter wrap, CNT_W=4: 17 load-use stalls. Required: stall_cnt=1.
